// File: rtl/tensor_index_iter.sv
// -----------------------------------------------------------------------------
// tensor_index_iter
//
// Address generator for the tensor write/assign engine. A start pulse captures
// the tensor configuration. The block then walks every element in row-major
// order, with dim RANK-1 changing fastest. Each element produces one
// valid/ready beat that carries:
//   - the flat element number,
//   - the per-dimension index,
//   - the storage offset, base + sum(idx[d]*stride[d]) mod 2^OFFW.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   start        one-cycle request; cfg_* sampled in the same cycle (IDLE only)
//   cfg_shape    RANK x DIMW shape, dim d at [d*DIMW +: DIMW]
//   cfg_stride   RANK x OFFW two's-complement stride, same packing
//   cfg_base     starting offset
//   busy         high while an iteration is in progress, through the done cycle
//   out_valid    beat valid
//   out_ready    downstream accepts the beat
//   out_offset   storage offset of the current element
//   out_index    per-dimension index, same packing as cfg_shape
//   out_nth      flat element number, 0-based
//   out_last     final beat of the iteration
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module tensor_index_iter #(
   parameter int RANK = 4,
   parameter int DIMW = 16,
   parameter int OFFW = 32,
   parameter int NW   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [RANK*DIMW-1:0] cfg_shape,
   input  logic [RANK*OFFW-1:0] cfg_stride,
   input  logic [OFFW-1:0]      cfg_base,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OFFW-1:0]      out_offset,
   output logic [RANK*DIMW-1:0] out_index,
   output logic [NW-1:0]        out_nth,
   output logic                 out_last,
   output logic                 done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   // Latched configuration.
   logic [DIMW-1:0] r_shape  [RANK];
   logic [OFFW-1:0] r_stride [RANK];

   // Odometer state. r_row[d] holds base + sum over j<=d of idx[j]*stride[j],
   // which is the offset with every dim faster than d at zero. The current
   // offset is therefore r_row[RANK-1]. When dim k steps, it adds its own
   // stride, and every faster dim (which wraps to 0) copies dim k's new row
   // value. This keeps the offset exact without any multiplier.
   logic [DIMW-1:0] r_idx [RANK];
   logic [OFFW-1:0] r_row [RANK];
   logic [NW-1:0]   r_nth;

   logic [RANK-1:0] w_wrap;      // dim d sits at its final index
   logic [RANK-1:0] w_step;      // dim d changes on the next advance
   logic            w_all_wrap;  // current beat is the last one
   logic            w_any_zero;  // requested shape contains an empty dim
   logic            w_accept;
   logic            w_xfer;
   logic [OFFW-1:0] w_row_next [RANK];

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_xfer   = (r_state == S_RUN) && out_ready;

   always_comb begin
      for (int d = 0; d < RANK; d++) begin
         w_wrap[d] = (r_idx[d] == r_shape[d] - DIMW'(1));
      end
   end

   // Carry ripples from the fastest dim toward dim 0. A dim steps only when
   // every faster dim is wrapping.
   always_comb begin : carry_chain
      logic v_carry;
      // NOTE: blocking assignments inside always_comb are correct; v_carry
      // must update in order as the loop walks the dims.
      v_carry = 1'b1;
      w_step  = '0;
      for (int d = RANK - 1; d >= 0; d--) begin
         w_step[d] = v_carry;
         v_carry   = v_carry & w_wrap[d];
      end
      w_all_wrap = v_carry;
   end

   // Next row-start values. The dim that increments adds its stride, and
   // each faster dim that wraps inherits the value from the dim above it.
   always_comb begin : row_chain
      logic [OFFW-1:0] v_prev;
      logic [OFFW-1:0] v_val;
      v_prev = r_row[0];
      for (int d = 0; d < RANK; d++) begin
         v_val = r_row[d];
         if (w_step[d] && !w_wrap[d]) begin
            v_val = r_row[d] + r_stride[d];
         end else if (w_step[d]) begin
            v_val = v_prev;
         end
         w_row_next[d] = v_val;
         v_prev        = v_val;
      end
   end

   always_comb begin
      w_any_zero = 1'b0;
      for (int d = 0; d < RANK; d++) begin
         if (cfg_shape[d*DIMW +: DIMW] == '0) begin
            w_any_zero = 1'b1;
         end
      end
   end

   // Next-state and control outputs.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a
      // variable unassigned and no latch is inferred.
      w_state_next = r_state;
      busy         = 1'b0;
      out_valid    = 1'b0;
      out_last     = 1'b0;
      done         = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = w_any_zero ? S_FLUSH : S_RUN;
            end
         end
         S_RUN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = w_all_wrap;
            if (out_ready && w_all_wrap) begin
               w_state_next = S_FLUSH;
            end
         end
         S_FLUSH: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Configuration storage is only read after a start has loaded it.
   // NOTE: these registers carry no reset on purpose; their contents are
   // don't-care until the first accepted start overwrites them.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int d = 0; d < RANK; d++) begin
            r_shape[d]  <= cfg_shape[d*DIMW +: DIMW];
            r_stride[d] <= cfg_stride[d*OFFW +: OFFW];
         end
      end
   end

   // State and datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only.
         r_state <= S_IDLE;
         r_nth   <= '0;
         for (int d = 0; d < RANK; d++) begin
            r_idx[d] <= '0;
            r_row[d] <= '0;
         end
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_nth <= '0;
            for (int d = 0; d < RANK; d++) begin
               r_idx[d] <= '0;
               r_row[d] <= cfg_base;
            end
         end else if (w_xfer && !w_all_wrap) begin
            r_nth <= r_nth + NW'(1);
            for (int d = 0; d < RANK; d++) begin
               if (w_step[d]) begin
                  r_idx[d] <= w_wrap[d] ? '0 : r_idx[d] + DIMW'(1);
               end
               r_row[d] <= w_row_next[d];
            end
         end
      end
   end

   assign out_offset = r_row[RANK-1];
   assign out_nth    = r_nth;

   for (genvar g = 0; g < RANK; g++) begin : g_index
      assign out_index[g*DIMW +: DIMW] = r_idx[g];
   end

endmodule

// File: tb/tb_tensor_index_iter.sv
// -----------------------------------------------------------------------------
// tb_tensor_index_iter
//
// Directed bench for tensor_index_iter. Each scenario task drives one
// iteration, records every beat and the per-cycle control outputs, and then
// compares them against hand-computed values. Cycle 1 is the first cycle
// after the start cycle.
// -----------------------------------------------------------------------------
module tb_tensor_index_iter;

   localparam int RANK = 4;
   localparam int DIMW = 16;
   localparam int OFFW = 32;
   localparam int NW   = 32;
   localparam int MAXC = 64;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [RANK*DIMW-1:0] cfg_shape;
   logic [RANK*OFFW-1:0] cfg_stride;
   logic [OFFW-1:0]      cfg_base;
   logic                 busy;
   logic                 out_valid;
   logic                 out_ready;
   logic [OFFW-1:0]      out_offset;
   logic [RANK*DIMW-1:0] out_index;
   logic [NW-1:0]        out_nth;
   logic                 out_last;
   logic                 done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tensor_index_iter #(
      .RANK (RANK),
      .DIMW (DIMW),
      .OFFW (OFFW),
      .NW   (NW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_shape  (cfg_shape),
      .cfg_stride (cfg_stride),
      .cfg_base   (cfg_base),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_offset (out_offset),
      .out_index  (out_index),
      .out_nth    (out_nth),
      .out_last   (out_last),
      .done       (done)
   );

   // Arguments are given dim 0 first; dim 0 occupies the low bits.
   function automatic logic [RANK*DIMW-1:0] pk_shape(input int d0, input int d1,
                                                     input int d2, input int d3);
      return {DIMW'(d3), DIMW'(d2), DIMW'(d1), DIMW'(d0)};
   endfunction

   function automatic logic [RANK*OFFW-1:0] pk_stride(input int s0, input int s1,
                                                      input int s2, input int s3);
      return {OFFW'(s3), OFFW'(s2), OFFW'(s1), OFFW'(s0)};
   endfunction

   // Results recorded by run_iter.
   logic [OFFW-1:0]      b_off [$];
   logic [RANK*DIMW-1:0] b_idx [$];
   logic [NW-1:0]        b_nth [$];
   logic                 b_last[$];
   logic                 c_busy [MAXC];
   logic                 c_valid[MAXC];
   logic [OFFW-1:0]      c_off  [MAXC];
   int first_valid, done_cyc, done_cnt, valid_cnt;

   // Runs one iteration. stall_mask[c] drops out_ready in cycle c. When
   // restart_at1 is set, a second start carrying a different shape is issued
   // in cycle 1. The task keeps watching for three cycles after done, and
   // gives up after MAXC cycles.
   task automatic run_iter(input logic [RANK*DIMW-1:0] shape,
                           input logic [RANK*OFFW-1:0] stride,
                           input logic [OFFW-1:0] base,
                           input logic [MAXC-1:0] stall_mask,
                           input bit restart_at1);
      b_off.delete(); b_idx.delete(); b_nth.delete(); b_last.delete();
      first_valid = -1; done_cyc = -1; done_cnt = 0; valid_cnt = 0;
      for (int i = 0; i < MAXC; i++) begin
         c_busy[i] = 1'b0; c_valid[i] = 1'b0; c_off[i] = '0;
      end
      @(negedge clk);
      cfg_shape  = shape;
      cfg_stride = stride;
      cfg_base   = base;
      start      = 1'b1;
      out_ready  = 1'b1;
      for (int c = 1; c < MAXC; c++) begin
         @(negedge clk);
         start = restart_at1 && (c == 1);
         if (start) cfg_shape = pk_shape(1, 1, 1, 2);
         out_ready  = !stall_mask[c];
         c_busy[c]  = busy;
         c_valid[c] = out_valid;
         c_off[c]   = out_offset;
         if (out_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = c;
         end
         if (out_valid && out_ready) begin
            b_off.push_back(out_offset);
            b_idx.push_back(out_index);
            b_nth.push_back(out_nth);
            b_last.push_back(out_last);
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
      end
      start     = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      cfg_shape = '0; cfg_stride = '0; cfg_base = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, out_valid, out_last, done} !== 4'b0000) begin
         bad++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, out_valid, out_last, done});
      end
      total++;
      if (out_offset !== '0 || out_index !== '0 || out_nth !== '0) begin
         bad++; $display("FAIL reset_data: off=%0h idx=%0h nth=%0d expected all 0", out_offset, out_index, out_nth);
      end
      rst = 1'b0;
   endtask

   task automatic check_six(input string name, input int exp_off[6]);
      total++;
      if (b_off.size() !== 6) begin
         bad++; $display("FAIL %s_count: got %0d beats expected 6", name, b_off.size());
      end
      for (int i = 0; i < 6 && i < b_off.size(); i++) begin
         total++;
         if (b_off[i] !== OFFW'(exp_off[i]) || b_nth[i] !== NW'(i) || b_last[i] !== (i == 5)) begin
            bad++;
            $display("FAIL %s_beat%0d: off=%0d nth=%0d last=%b expected off=%0d nth=%0d last=%b",
                     name, i, b_off[i], b_nth[i], b_last[i], exp_off[i], i, (i == 5));
         end
      end
   endtask

   task automatic test_basic();
      int exp_off[6] = '{100, 101, 102, 103, 104, 105};
      run_iter(pk_shape(1, 1, 2, 3), pk_stride(0, 0, 3, 1), 32'd100, '0, 1'b0);
      check_six("basic", exp_off);
      total++;
      if (first_valid !== 1) begin
         bad++; $display("FAIL basic_latency: first valid cycle %0d expected 1", first_valid);
      end
      total++;
      if (done_cyc !== 7 || done_cnt !== 1) begin
         bad++; $display("FAIL basic_done: cycle %0d count %0d expected cycle 7 count 1", done_cyc, done_cnt);
      end
      total++;
      if (c_busy[1] !== 1'b1 || c_busy[7] !== 1'b1 || c_busy[8] !== 1'b0) begin
         bad++; $display("FAIL basic_busy: c1=%b c7=%b c8=%b expected 1 1 0", c_busy[1], c_busy[7], c_busy[8]);
      end
      total++;
      if (b_idx.size() == 6 && b_idx[4] !== pk_shape(0, 0, 1, 1)) begin
         bad++; $display("FAIL basic_index4: got %0h expected %0h", b_idx[4], pk_shape(0, 0, 1, 1));
      end
   endtask

   task automatic test_transpose();
      int exp_off[6] = '{0, 2, 4, 1, 3, 5};
      run_iter(pk_shape(1, 1, 2, 3), pk_stride(0, 0, 1, 2), 32'd0, '0, 1'b0);
      check_six("transpose", exp_off);
      total++;
      if (b_idx.size() < 4 || b_idx[3] !== pk_shape(0, 0, 1, 0)) begin
         bad++; $display("FAIL transpose_index3: got %0h expected %0h",
                         (b_idx.size() < 4) ? '0 : b_idx[3], pk_shape(0, 0, 1, 0));
      end
   endtask

   task automatic test_backpressure();
      logic [MAXC-1:0] mask;
      mask = '0;
      mask[2] = 1'b1; mask[3] = 1'b1; mask[4] = 1'b1;
      run_iter(pk_shape(1, 1, 1, 4), pk_stride(0, 0, 0, 1), 32'd0, mask, 1'b0);
      total++;
      if (b_off.size() !== 4) begin
         bad++; $display("FAIL bp_count: got %0d beats expected 4", b_off.size());
      end
      for (int i = 0; i < 4 && i < b_off.size(); i++) begin
         total++;
         if (b_off[i] !== OFFW'(i) || b_nth[i] !== NW'(i)) begin
            bad++; $display("FAIL bp_beat%0d: off=%0d nth=%0d expected %0d", i, b_off[i], b_nth[i], i);
         end
      end
      for (int c = 2; c <= 4; c++) begin
         total++;
         if (c_valid[c] !== 1'b1 || c_off[c] !== 32'd1) begin
            bad++; $display("FAIL bp_hold_c%0d: valid=%b off=%0d expected 1 1", c, c_valid[c], c_off[c]);
         end
      end
      total++;
      if (done_cyc !== 8) begin
         bad++; $display("FAIL bp_done: cycle %0d expected 8", done_cyc);
      end
   endtask

   task automatic test_negative_stride();
      logic [OFFW-1:0] exp_a[3] = '{32'd2, 32'd1, 32'd0};
      logic [OFFW-1:0] exp_b[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      run_iter(pk_shape(1, 1, 1, 3), pk_stride(0, 0, 0, -1), 32'd2, '0, 1'b0);
      total++;
      if (b_off.size() !== 3) begin
         bad++; $display("FAIL neg_a_count: got %0d expected 3", b_off.size());
      end
      for (int i = 0; i < 3 && i < b_off.size(); i++) begin
         total++;
         if (b_off[i] !== exp_a[i]) begin
            bad++; $display("FAIL neg_a_beat%0d: got %0h expected %0h", i, b_off[i], exp_a[i]);
         end
      end
      run_iter(pk_shape(1, 1, 1, 3), pk_stride(0, 0, 0, -1), 32'd0, '0, 1'b0);
      total++;
      if (b_off.size() !== 3) begin
         bad++; $display("FAIL neg_b_count: got %0d expected 3", b_off.size());
      end
      for (int i = 0; i < 3 && i < b_off.size(); i++) begin
         total++;
         if (b_off[i] !== exp_b[i] || b_last[i] !== (i == 2)) begin
            bad++; $display("FAIL neg_b_beat%0d: off=%0h last=%b expected %0h %b",
                            i, b_off[i], b_last[i], exp_b[i], (i == 2));
         end
      end
   endtask

   task automatic test_zero_dim();
      run_iter(pk_shape(2, 0, 3, 3), pk_stride(9, 3, 1, 1), 32'd7, '0, 1'b1);
      total++;
      if (valid_cnt !== 0) begin
         bad++; $display("FAIL zero_valid: got %0d valid cycles expected 0", valid_cnt);
      end
      total++;
      if (done_cyc !== 1 || done_cnt !== 1) begin
         bad++; $display("FAIL zero_done: cycle %0d count %0d expected cycle 1 count 1", done_cyc, done_cnt);
      end
      total++;
      if (c_busy[1] !== 1'b1 || c_busy[2] !== 1'b0) begin
         bad++; $display("FAIL zero_busy: c1=%b c2=%b expected 1 0", c_busy[1], c_busy[2]);
      end
   endtask

   task automatic test_reset_mid_run();
      int exp_off[6] = '{100, 101, 102, 103, 104, 105};
      bit saw_bad;
      @(negedge clk);
      cfg_shape  = pk_shape(1, 1, 2, 3);
      cfg_stride = pk_stride(0, 0, 3, 1);
      cfg_base   = 32'd100;
      out_ready  = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_offset !== 32'd102 || out_nth !== 32'd2) begin
         bad++; $display("FAIL midrst_pre: valid=%b off=%0d nth=%0d expected 1 102 2", out_valid, out_offset, out_nth);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, out_valid, out_last, done} !== 4'b0000 || out_offset !== '0 ||
          out_index !== '0 || out_nth !== '0) begin
         bad++; $display("FAIL midrst_clear: ctrl=%b off=%0d idx=%0h nth=%0d expected all 0",
                         {busy, out_valid, out_last, done}, out_offset, out_index, out_nth);
      end
      rst = 1'b0;
      saw_bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done || out_valid) saw_bad = 1'b1;
      end
      total++;
      if (saw_bad !== 1'b0) begin
         bad++; $display("FAIL midrst_quiet: got activity=%b expected 0", saw_bad);
      end
      run_iter(pk_shape(1, 1, 2, 3), pk_stride(0, 0, 3, 1), 32'd100, '0, 1'b0);
      check_six("midrst_restart", exp_off);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_transpose();
      test_backpressure();
      test_negative_stride();
      test_zero_dim();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
